// File: rtl/formula_2_pipe_fifo_bp.sv
// Three-stage pipeline computing res = isqrt(a + isqrt(b + isqrt(c))). The operands are
// delay-aligned in FIFOs, and a credit count throttles arg_rdy so the output FIFO cannot overflow.

module Isqrt #(
  parameter int WIDTH = 32,
  parameter int LAT   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x_vld,
  input  logic [WIDTH-1:0]   x,
  output logic               y_vld,
  output logic [WIDTH/2-1:0] y
);
  localparam int HW = WIDTH / 2;

  logic [LAT-1:0] vld_q;
  logic [HW-1:0]  y_q [LAT];

  function automatic logic [HW-1:0] root_of(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] op;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] one;
    op  = v;
    acc = '0;
    one = {2'b01, {(WIDTH-2){1'b0}}};
    for (int i = 0; i < HW; i++) begin
      if (op >= acc + one) begin
        op  = op - (acc + one);
        acc = (acc >> 1) + one;
      end else begin
        acc = acc >> 1;
      end
      one = one >> 2;
    end
    return acc[HW-1:0];
  endfunction

  // The first stage resolves the root. Later stages only delay it, so the latency is exactly LAT.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= x_vld;
      for (int i = 1; i < LAT; i++) vld_q[i] <= vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    y_q[0] <= root_of(x);
    for (int i = 1; i < LAT; i++) y_q[i] <= y_q[i-1];
  end

  assign y_vld = vld_q[LAT-1];
  assign y     = y_q[LAT-1];
endmodule

module SyncFifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  // Pointers wrap explicitly because DEPTH is not restricted to a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

module formula_2_pipe_fifo_bp #(
  parameter int WIDTH     = 32,
  parameter int ISQRT_LAT = 16,
  parameter int OUT_DEPTH = 52
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           arg_vld,
  output logic                           arg_rdy,
  input  logic [WIDTH-1:0]               a,
  input  logic [WIDTH-1:0]               b,
  input  logic [WIDTH-1:0]               c,
  output logic                           res_vld,
  input  logic                           res_rdy,
  output logic [WIDTH-1:0]               res,
  output logic [$clog2(OUT_DEPTH+1)-1:0] in_flight,
  output logic                           err
);
  localparam int HW       = WIDTH / 2;
  localparam int CW       = $clog2(OUT_DEPTH + 1);
  localparam int FB_DEPTH = ISQRT_LAT + 2;
  localparam int FA_DEPTH = 2 * ISQRT_LAT + 3;

  logic             accept, pop;
  logic             y1_vld, y2_vld, y3_vld;
  logic [HW-1:0]    y1, y2, y3;
  logic [WIDTH-1:0] b_head, a_head;
  logic             b_empty, b_full, a_empty, a_full, out_empty, out_full;
  logic             s1_vld, s2_vld;
  logic [WIDTH-1:0] s1, s2;

  assign arg_rdy = ~rst & (in_flight < CW'(OUT_DEPTH));
  assign accept  = arg_vld & arg_rdy;
  assign res_vld = ~out_empty;
  assign pop     = res_vld & res_rdy;

  Isqrt #(.WIDTH(WIDTH), .LAT(ISQRT_LAT)) u_isqrt1 (
    .clk(clk), .rst(rst), .x_vld(accept), .x(c), .y_vld(y1_vld), .y(y1));

  SyncFifo #(.WIDTH(WIDTH), .DEPTH(FB_DEPTH)) u_fifo_b (
    .clk(clk), .rst(rst), .push(accept), .push_data(b), .pop(y1_vld),
    .head(b_head), .empty(b_empty), .full(b_full));

  SyncFifo #(.WIDTH(WIDTH), .DEPTH(FA_DEPTH)) u_fifo_a (
    .clk(clk), .rst(rst), .push(accept), .push_data(a), .pop(y2_vld),
    .head(a_head), .empty(a_empty), .full(a_full));

  // The s1/s2 registers add one cycle per stage, so the latency is 3*ISQRT_LAT+2 to the output push.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s1     <= '0;
      s2     <= '0;
    end else begin
      s1_vld <= y1_vld;
      s2_vld <= y2_vld;
      if (y1_vld) s1 <= {{(WIDTH-HW){1'b0}}, y1} + b_head;
      if (y2_vld) s2 <= {{(WIDTH-HW){1'b0}}, y2} + a_head;
    end
  end

  Isqrt #(.WIDTH(WIDTH), .LAT(ISQRT_LAT)) u_isqrt2 (
    .clk(clk), .rst(rst), .x_vld(s1_vld), .x(s1), .y_vld(y2_vld), .y(y2));

  Isqrt #(.WIDTH(WIDTH), .LAT(ISQRT_LAT)) u_isqrt3 (
    .clk(clk), .rst(rst), .x_vld(s2_vld), .x(s2), .y_vld(y3_vld), .y(y3));

  SyncFifo #(.WIDTH(WIDTH), .DEPTH(OUT_DEPTH)) u_fifo_out (
    .clk(clk), .rst(rst), .push(y3_vld), .push_data({{(WIDTH-HW){1'b0}}, y3}), .pop(pop),
    .head(res), .empty(out_empty), .full(out_full));

  // A credit is taken on accept and returned on pop. The count is registered, so res_rdy has no combinational path to arg_rdy.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   in_flight <= in_flight + 1'b1;
        2'b01:   in_flight <= in_flight - 1'b1;
        default: in_flight <= in_flight;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if ((accept & (b_full | a_full)) | (y1_vld & b_empty) |
                 (y2_vld & a_empty) | (y3_vld & out_full)) begin
      err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_formula_2_pipe_fifo_bp.sv
// Scoreboard bench for formula_2_pipe_fifo_bp: a reference model queues the expected results,
// and the queue size serves as the expected credit count.

module tb_formula_2_pipe_fifo_bp;
  localparam int WIDTH = 32;
  localparam int L     = 16;
  localparam int DEPTH = 52;
  localparam int LAT   = 3 * L + 3;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic                         arg_vld = 1'b0;
  logic                         res_rdy = 1'b0;
  logic [WIDTH-1:0]             a = '0, b = '0, c = '0;
  logic                         arg_rdy, res_vld, err;
  logic [WIDTH-1:0]             res;
  logic [$clog2(DEPTH+1)-1:0]   in_flight;

  int               n_compared = 0;
  int               n_mismatched = 0;
  int               n_accepts = 0;
  logic [WIDTH-1:0] exp_q [$];

  always #5 clk = ~clk;

  formula_2_pipe_fifo_bp #(.WIDTH(WIDTH), .ISQRT_LAT(L), .OUT_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .arg_vld(arg_vld), .arg_rdy(arg_rdy), .a(a), .b(b), .c(c),
    .res_vld(res_vld), .res_rdy(res_rdy), .res(res), .in_flight(in_flight), .err(err));

  function automatic logic [WIDTH-1:0] refIsqrt(input logic [WIDTH-1:0] v);
    logic [63:0] r;
    logic [63:0] t;
    r = 64'd0;
    for (int i = WIDTH/2 - 1; i >= 0; i--) begin
      t = r | (64'd1 << i);
      if (t * t <= {32'd0, v}) r = t;
    end
    return r[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] refFormula(input logic [WIDTH-1:0] ta, tb_, tc);
    logic [WIDTH-1:0] s1, s2;
    s1 = refIsqrt(tc) + tb_;
    s2 = refIsqrt(s1) + ta;
    return refIsqrt(s2);
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] ta, tb_, tc);
    @(posedge clk); #1;
    a = ta; b = tb_; c = tc; arg_vld = 1'b1;
    @(posedge clk); #1;
    arg_vld = 1'b0;
  endtask

  task automatic waitResult(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!res_vld && k < 200);
  endtask

  // Scoreboard: the credit count and arg_rdy are checked against the queue before this cycle's events are applied.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      checkOutput("rdy_in_reset", arg_rdy, 0);
    end else begin
      checkOutput("in_flight", in_flight, exp_q.size());
      checkOutput("arg_rdy", arg_rdy, exp_q.size() < DEPTH);
      checkOutput("err", err, 0);
      if (res_vld && res_rdy) begin
        if (exp_q.size() == 0) checkOutput("stale_res", res_vld, 0);
        else checkOutput("res", res, exp_q.pop_front());
      end
      if (arg_vld && arg_rdy) begin
        exp_q.push_back(refFormula(a, b, c));
        n_accepts++;
      end
    end
  end

  initial begin
    int k;
    int cnt;
    int start;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_res_vld", res_vld, 0);
    checkOutput("rst_res", res, 0);
    checkOutput("rst_in_flight", in_flight, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_arg_rdy", arg_rdy, 1);

    res_rdy = 1'b1;
    applyStimulus(32'd0, 32'd0, 32'd16);
    waitResult(k);
    checkOutput("t1_latency", k, LAT);
    checkOutput("t1_res", res, 1);
    @(negedge clk);
    checkOutput("t1_in_flight", in_flight, 0);

    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (i % 2 == 0) begin a = 32'd1;  b = 32'd5;  c = 32'd16; end
      else            begin a = 32'd12; b = 32'd12; c = 32'd16; end
      arg_vld = 1'b1;
      @(negedge clk);
      if (res_vld) cnt++;
    end
    @(posedge clk); #1 arg_vld = 1'b0;
    checkOutput("t2_results_no_gaps", cnt, 200 - LAT);
    repeat (60) @(posedge clk);

    applyStimulus(32'd9, 32'hFFFF_FFFF, 32'd1);
    waitResult(k);
    checkOutput("t3_latency", k, LAT);
    checkOutput("t3_res", res, 3);
    repeat (3) @(posedge clk);

    #1 res_rdy = 1'b0;
    cnt = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      a = 32'(i); b = 32'(i * 3); c = 32'(i * i * 977); arg_vld = 1'b1;
      @(negedge clk);
      if (arg_vld && arg_rdy) cnt++;
    end
    checkOutput("t4_accepts", cnt, DEPTH);
    checkOutput("t4_rdy_low", arg_rdy, 0);
    checkOutput("t4_full_vld", res_vld, 1);
    @(posedge clk); #1;
    arg_vld = 1'b0; res_rdy = 1'b1;
    cnt = 0;
    @(negedge clk);
    checkOutput("t4_rdy_pop_cycle", arg_rdy, 0);
    if (res_vld) cnt++;
    @(negedge clk);
    checkOutput("t4_rdy_after_pop", arg_rdy, 1);
    if (res_vld) cnt++;
    repeat (58) begin
      @(negedge clk);
      if (res_vld) cnt++;
    end
    checkOutput("t4_drain_count", cnt, DEPTH);

    start = n_accepts;
    k = 0;
    while (n_accepts - start < 10000 && k < 35000) begin
      @(posedge clk); #1;
      a = $urandom; b = $urandom;
      c = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
      arg_vld = 1'b1;
      res_rdy = 1'($urandom_range(0, 1));
      k++;
    end
    @(posedge clk); #1;
    arg_vld = 1'b0; res_rdy = 1'b1;
    checkOutput("t5_accept_budget", (n_accepts - start) >= 10000, 1);
    k = 0;
    while (exp_q.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    checkOutput("t5_drained", exp_q.size(), 0);
    checkOutput("t5_err", err, 0);

    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      a = $urandom; b = $urandom; c = $urandom; arg_vld = 1'b1;
    end
    @(posedge clk); #1;
    arg_vld = 1'b0; rst = 1'b1; res_rdy = 1'b0;
    @(negedge clk);
    checkOutput("t6_in_flight_pre", in_flight, 30);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    checkOutput("t6_res_vld", res_vld, 0);
    checkOutput("t6_in_flight", in_flight, 0);
    cnt = 0;
    repeat (80) begin
      @(negedge clk);
      if (res_vld) cnt++;
    end
    checkOutput("t6_no_stale", cnt, 0);
    res_rdy = 1'b1;
    applyStimulus(32'd7, 32'd9, 32'd100);
    waitResult(k);
    checkOutput("t6_latency", k, LAT);
    checkOutput("t6_res", res, refFormula(32'd7, 32'd9, 32'd100));
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end
endmodule
